// File: rtl/ahb_dma_read_master.sv
// AHB-Lite read master: turns one staged DMA command into an INCR word burst
// and streams each returned word out with a single-cycle valid strobe.
module ahb_dma_read_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_cmd_valid,
  input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0] i_RCC_DMA_ADDR_LOW,
  input  logic [5:0]  i_RCC_BUFFER_LENGTH,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

  state_t      state, state_nx;
  logic [31:0] haddr_nx;
  logic [1:0]  htrans_nx;
  logic [5:0]  addr_left, addr_left_nx;
  logic        data_pend, data_pend_nx;
  logic [31:0] rd_data_nx;
  logic        rd_valid_nx, busy_nx, done_nx, error_nx;
  logic [31:0] addr_inc;
  logic        unused_addr_bits;

  assign HWRITE    = 1'b0;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b001;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign addr_inc         = HADDR + 32'd4;
  assign unused_addr_bits = ^i_RCC_DMA_ADDR_LOW[1:0];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // addr_left counts address phases still to be accepted, including the one on the bus
  always_comb begin
    state_nx     = state;
    haddr_nx     = HADDR;
    htrans_nx    = HTRANS;
    addr_left_nx = addr_left;
    data_pend_nx = data_pend;
    rd_data_nx   = o_rd_data;
    rd_valid_nx  = 1'b0;
    done_nx      = 1'b0;
    error_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (i_RCC_BUFFER_LENGTH == 6'd0) begin
            done_nx = 1'b1;
          end else begin
            state_nx     = S_ADDR;
            haddr_nx     = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
            htrans_nx    = TRANS_NONSEQ;
            addr_left_nx = i_RCC_BUFFER_LENGTH;
            data_pend_nx = 1'b0;
          end
        end
      end
      S_ADDR: begin
        if (data_pend && !HREADY && HRESP) begin
          htrans_nx = TRANS_IDLE;
          state_nx  = S_ERR;
        end else if (HREADY) begin
          if (data_pend && !HRESP) begin
            rd_data_nx  = HRDATA;
            rd_valid_nx = 1'b1;
          end
          data_pend_nx = 1'b1;
          if (addr_left == 6'd1) begin
            htrans_nx = TRANS_IDLE;
            state_nx  = S_LAST;
          end else begin
            // a burst may not cross a 1 KB boundary, so restart it there
            haddr_nx     = addr_inc;
            htrans_nx    = (addr_inc[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
            addr_left_nx = addr_left - 6'd1;
          end
        end
      end
      S_LAST: begin
        if (!HREADY && HRESP) begin
          state_nx = S_ERR;
        end else if (HREADY) begin
          if (HRESP) begin
            error_nx = 1'b1;
          end else begin
            rd_data_nx  = HRDATA;
            rd_valid_nx = 1'b1;
            done_nx     = 1'b1;
          end
          data_pend_nx = 1'b0;
          state_nx     = S_IDLE;
        end
      end
      S_ERR: begin
        htrans_nx = TRANS_IDLE;
        if (HREADY) begin
          error_nx     = 1'b1;
          data_pend_nx = 1'b0;
          state_nx     = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state != S_IDLE) || (state_nx != S_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HADDR      <= 32'd0;
      HTRANS     <= TRANS_IDLE;
      addr_left  <= 6'd0;
      data_pend  <= 1'b0;
      o_rd_data  <= 32'd0;
      o_rd_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      HADDR      <= haddr_nx;
      HTRANS     <= htrans_nx;
      addr_left  <= addr_left_nx;
      data_pend  <= data_pend_nx;
      o_rd_data  <= rd_data_nx;
      o_rd_valid <= rd_valid_nx;
      o_busy     <= busy_nx;
      o_done     <= done_nx;
      o_error    <= error_nx;
    end
  end

endmodule

// File: tb/tb_ahb_dma_read_master.sv
// Bench for ahb_dma_read_master: a reactive AHB slave plus a burst-level model
// predicting addresses, data order, completion timing and error behaviour.
module tb_ahb_dma_read_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [15:0] i_RCC_DMA_ADDR_HIGH = '0;
  logic [15:0] i_RCC_DMA_ADDR_LOW = '0;
  logic [5:0]  i_RCC_BUFFER_LENGTH = '0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_busy, o_done, o_error;

  ahb_dma_read_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_cmd_valid(i_cmd_valid),
    .i_RCC_DMA_ADDR_HIGH(i_RCC_DMA_ADDR_HIGH), .i_RCC_DMA_ADDR_LOW(i_RCC_DMA_ADDR_LOW),
    .i_RCC_BUFFER_LENGTH(i_RCC_BUFFER_LENGTH), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cmd_cyc = 0;

  int          wait_tab[64];
  int          err_idx = -1;
  logic [31:0] salt = 32'h0;

  logic [31:0] addr_log[$];
  logic [1:0]  trans_log[$];
  logic [31:0] data_log[$];
  int          valid_cyc_q[$];
  int done_cnt = 0, err_cnt = 0, last_done_cyc = -1, busy_cycles = 0, nonidle_cycles = 0;
  int hold_viol = 0, err_trans_viol = 0, err_first_seen = 0;
  int hold_cyc = -1, err_chk_cyc = -1;
  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;

  bit          dp_active = 1'b0;
  bit          dp_err_stage = 1'b0;
  logic [31:0] dp_addr;
  int          dp_idx = 0, dp_waits = 0, word_cnt = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E3779B1) ^ s;
  endfunction

  // Slave: samples the bus at the edge, then drives its response 1 time unit later
  always @(posedge HCLK) begin
    cyc++;
    if (!HRESETn) begin
      dp_active = 1'b0;
    end else begin
      if (i_cmd_valid && !o_busy) word_cnt = 0;
      if (HREADY === 1'b0 && HRESP === 1'b1) begin
        err_first_seen++;
        err_chk_cyc = cyc;
      end
      if (HREADY === 1'b0 && HRESP === 1'b0 && HTRANS != 2'b00) begin
        hold_cyc   = cyc;
        hold_addr  = HADDR;
        hold_trans = HTRANS;
      end
      if (HREADY) begin
        if (HTRANS[1]) begin
          addr_log.push_back(HADDR);
          trans_log.push_back(HTRANS);
          dp_active    = 1'b1;
          dp_addr      = HADDR;
          dp_idx       = word_cnt;
          word_cnt++;
          dp_waits     = wait_tab[dp_idx % 64];
          dp_err_stage = 1'b0;
        end else begin
          dp_active = 1'b0;
        end
      end else if (dp_active) begin
        if (dp_idx == err_idx) dp_err_stage = 1'b1;
        else if (dp_waits > 0) dp_waits--;
      end
    end
    #1;
    if (dp_active && dp_idx == err_idx) begin
      HREADY = dp_err_stage;
      HRESP  = 1'b1;
      HRDATA = $urandom;
    end else if (dp_active && dp_waits > 0) begin
      HREADY = 1'b0;
      HRESP  = 1'b0;
      HRDATA = $urandom;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = dp_active ? slave_data(dp_addr, salt) : 32'hDEAD_BEEF;
    end
  end

  always @(negedge HCLK) begin
    if (o_rd_valid === 1'b1) begin
      data_log.push_back(o_rd_data);
      valid_cyc_q.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (o_error === 1'b1) err_cnt++;
    if (o_busy === 1'b1) busy_cycles++;
    if (HTRANS !== 2'b00 && !$isunknown(HTRANS)) nonidle_cycles++;
    if (hold_cyc == cyc && (HADDR !== hold_addr || HTRANS !== hold_trans)) hold_viol++;
    if (err_chk_cyc == cyc && HTRANS !== 2'b00) err_trans_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_waits();
    for (int i = 0; i < 64; i++) wait_tab[i] = 0;
  endtask

  // Issues one command and compares the whole burst with the model.
  // err < 0 means no error; extra_at > 0 pulses a second strobe in that cycle.
  task automatic run_cmd(input string name, input logic [31:0] addr, input int len,
                         input int err, input int extra_at);
    int b_addr, b_data, b_done, b_err, b_busy, b_nonidle, b_hold, b_errv, b_efs;
    int waits_sum, n_acc, n_words;
    logic [31:0] ea, a;
    logic [1:0]  et;
    bit timed_out;
    b_addr = addr_log.size();  b_data = data_log.size();
    b_done = done_cnt;  b_err = err_cnt;  b_busy = busy_cycles;
    b_nonidle = nonidle_cycles;  b_hold = hold_viol;
    b_errv = err_trans_viol;  b_efs = err_first_seen;
    err_idx = err;
    waits_sum = 0;
    for (int i = 0; i < len; i++) waits_sum += wait_tab[i];
    i_RCC_DMA_ADDR_HIGH = addr[31:16];
    i_RCC_DMA_ADDR_LOW  = addr[15:0];
    i_RCC_BUFFER_LENGTH = len[5:0];
    i_cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    cmd_cyc = cyc;
    i_cmd_valid = 1'b0;
    timed_out = 1'b1;
    for (int k = 1; k < 600; k++) begin
      if (k == extra_at) begin
        i_cmd_valid = 1'b1;
        i_RCC_BUFFER_LENGTH = 6'd7;
        i_RCC_DMA_ADDR_HIGH = ~i_RCC_DMA_ADDR_HIGH;
      end else begin
        i_cmd_valid = 1'b0;
      end
      @(posedge HCLK); #1;
      if (k >= 3 && !o_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    i_cmd_valid = 1'b0;
    repeat (2) begin @(posedge HCLK); #1; end

    ea      = {addr[31:2], 2'b00};
    n_acc   = (err >= 0) ? err + 1 : len;
    n_words = (err >= 0) ? err : len;
    check({name, "/timeout"}, 32'(timed_out), 32'd0);
    check({name, "/n_addr"}, addr_log.size() - b_addr, n_acc);
    for (int i = 0; i < n_acc && b_addr + i < addr_log.size(); i++) begin
      a  = ea + 32'(4 * i);
      et = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
      check($sformatf("%s/haddr%0d", name, i), addr_log[b_addr + i], a);
      check($sformatf("%s/htrans%0d", name, i), 32'(trans_log[b_addr + i]), 32'(et));
    end
    check({name, "/n_words"}, data_log.size() - b_data, n_words);
    for (int i = 0; i < n_words && b_data + i < data_log.size(); i++)
      check($sformatf("%s/data%0d", name, i), data_log[b_data + i],
            slave_data(ea + 32'(4 * i), salt));
    check({name, "/done_cnt"}, done_cnt - b_done, (err < 0) ? 1 : 0);
    check({name, "/error_cnt"}, err_cnt - b_err, (err >= 0) ? 1 : 0);
    check({name, "/hold"}, hold_viol - b_hold, 0);
    if (err < 0) begin
      check({name, "/done_cycle"}, last_done_cyc - cmd_cyc + 1,
            (len == 0) ? 1 : len + 2 + waits_sum);
      check({name, "/busy_cycles"}, busy_cycles - b_busy,
            (len == 0) ? 0 : len + 2 + waits_sum);
      if (len == 0) check({name, "/nonidle"}, nonidle_cycles - b_nonidle, 0);
      else if (data_log.size() > b_data)
        check({name, "/first_valid_cycle"}, valid_cyc_q[b_data] - cmd_cyc + 1, 3 + wait_tab[0]);
    end else begin
      check({name, "/err_seen"}, err_first_seen - b_efs, 1);
      check({name, "/err_htrans_idle"}, err_trans_viol - b_errv, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nv;
    int b_data, b_addr;
    bit timed_out;
    logic [31:0] ra;
    int rl, re;

    zero_waits();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst/haddr", HADDR, 32'd0);
    check("rst/htrans", 32'(HTRANS), 32'd0);
    check("rst/rd_data", o_rd_data, 32'd0);
    check("rst/rd_valid", 32'(o_rd_valid), 32'd0);
    check("rst/busy", 32'(o_busy), 32'd0);
    check("rst/done", 32'(o_done), 32'd0);
    check("rst/error", 32'(o_error), 32'd0);
    check("const/hwrite", 32'(HWRITE), 32'd0);
    check("const/hsize", 32'(HSIZE), 32'd2);
    check("const/hburst", 32'(HBURST), 32'd1);
    check("const/hprot", 32'(HPROT), 32'd3);
    check("const/hmastlock", 32'(HMASTLOCK), 32'd0);
    HRESETn = 1'b1;
    repeat (2) begin @(posedge HCLK); #1; end

    salt = $urandom;
    run_cmd("incr4", 32'h2000_0010, 4, -1, 0);
    run_cmd("kb_cross", 32'h0000_03F8, 3, -1, 0);
    run_cmd("wrap", 32'hFFFF_FFFA, 3, -1, 0);
    wait_tab[1] = 2;
    run_cmd("wait2", 32'h1000_0100, 4, -1, 0);
    zero_waits();
    run_cmd("err2", 32'h4000_0000, 8, 2, 0);
    run_cmd("after_err", 32'h4000_0040, 5, -1, 0);
    run_cmd("len0", 32'h5000_0000, 0, -1, 0);
    run_cmd("ignore", 32'h5000_0100, 5, -1, 2);

    for (int t = 0; t < 12; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra[9:4] = 6'h3F;
      rl = $urandom_range(1, 20);
      re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
      for (int i = 0; i < 64; i++) wait_tab[i] = $urandom_range(0, 2);
      salt = $urandom;
      run_cmd($sformatf("rand%0d", t), ra, rl, re, 0);
    end

    // Reset asserted while word 3 of 10 is in its data phase
    zero_waits();
    err_idx = -1;
    salt = $urandom;
    b_data = data_log.size();
    i_RCC_DMA_ADDR_HIGH = 16'h6000;
    i_RCC_DMA_ADDR_LOW  = 16'h0000;
    i_RCC_BUFFER_LENGTH = 6'd10;
    i_cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    i_cmd_valid = 1'b0;
    nv = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge HCLK); #1;
      if (o_rd_valid) nv++;
      if (nv == 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("midrst/timeout", 32'(timed_out), 32'd0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    b_addr = addr_log.size();
    check("midrst/htrans", 32'(HTRANS), 32'd0);
    check("midrst/busy", 32'(o_busy), 32'd0);
    check("midrst/haddr", HADDR, 32'd0);
    check("midrst/rd_valid", 32'(o_rd_valid), 32'd0);
    check("midrst/done", 32'(o_done), 32'd0);
    HRESETn = 1'b1;
    repeat (6) begin @(posedge HCLK); #1; end
    check("midrst/words", data_log.size() - b_data, 3);
    check("midrst/no_more_addr", addr_log.size() - b_addr, 0);
    check("midrst/busy_after", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
